// File: rtl/video_capture_pkg.sv
// video_capture_pkg: capture FSM encoding and default raster timing
// shared by the frame-capture front end.
package video_capture_pkg;

   typedef enum logic [1:0] {
      CAP_WAIT_VSYNC = 2'd0,
      CAP_WAIT_LINE  = 2'd1,
      CAP_H_PORCH    = 2'd2,
      CAP_ACTIVE     = 2'd3
   } cap_state_e;

   localparam int DEF_PIXEL_DIV  = 4;
   localparam int DEF_H_OFFSET   = 32;
   localparam int DEF_H_PIXELS   = 256;
   localparam int DEF_V_OFFSET   = 16;
   localparam int DEF_V_LINES    = 192;
   localparam int DEF_VSYNC_MIN  = 64;
   localparam int DEF_ADDR_WIDTH = 13;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/video_capture_sync_detect.sv
// video_capture_sync_detect: measures sync pulse width and classifies
// each falling edge as hsync or vsync.
module video_capture_sync_detect
   import video_capture_pkg::*;
#(
   parameter int VSYNC_MIN = DEF_VSYNC_MIN
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sync_i,
   output logic hsyncEvt_o,
   output logic vsyncEvt_o,
   output logic syncRise_o
);

   localparam int LEN_W = $clog2(VSYNC_MIN + 1);
   localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(VSYNC_MIN);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   logic [LEN_W-1:0] syncLen_q;
   logic [LEN_W-1:0] syncLen_d;
   logic             syncPrev_q;
   logic             fall;

   always_comb begin
      syncLen_d = '0;
      if (sync_i) begin
         syncLen_d = (syncLen_q == LEN_SAT) ? syncLen_q
                                            : syncLen_q + LEN_ONE;
      end
      // syncLen_q still holds the full pulse width on the first low cycle
      fall       = syncPrev_q & ~sync_i;
      vsyncEvt_o = fall & (syncLen_q == LEN_SAT);
      hsyncEvt_o = fall & (syncLen_q != LEN_SAT);
      syncRise_o = sync_i & ~syncPrev_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         syncLen_q  <= '0;
         syncPrev_q <= 1'b0;
      end else begin
         syncLen_q  <= syncLen_d;
         syncPrev_q <= sync_i;
      end
   end

endmodule

// File: rtl/video_capture.sv
// video_capture: rebuilds the displayed frame from videoSync/videoPixel
// and emits it as packed bytes on a frame-buffer write port.
module video_capture
   import video_capture_pkg::*;
#(
   parameter int PIXEL_DIV  = DEF_PIXEL_DIV,
   parameter int H_OFFSET   = DEF_H_OFFSET,
   parameter int H_PIXELS   = DEF_H_PIXELS,
   parameter int V_OFFSET   = DEF_V_OFFSET,
   parameter int V_LINES    = DEF_V_LINES,
   parameter int VSYNC_MIN  = DEF_VSYNC_MIN,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  videoSync,
   input  logic                  videoPixel,
   output logic                  wrEn,
   output logic [ADDR_WIDTH-1:0] wrAddr,
   output logic [7:0]            wrData,
   output logic                  frameDone,
   output logic [7:0]            frameCount,
   output logic                  syncError
);

   localparam int BPR      = H_PIXELS / 8;
   localparam int LINE_END = V_OFFSET + V_LINES;
   localparam int LINE_W   = $clog2(LINE_END + 1);
   localparam int PIX_W    = $clog2(H_PIXELS);
   localparam int DOT_W    = $clog2(max2(H_OFFSET, PIXEL_DIV) + 1);

   localparam logic [ADDR_WIDTH-1:0] BPR_A = ADDR_WIDTH'(BPR);
   localparam logic [LINE_W-1:0] LINE_FIRST = LINE_W'(V_OFFSET);
   localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(LINE_END - 1);
   localparam logic [LINE_W-1:0] LINE_SAT   = LINE_W'(LINE_END);
   localparam logic [LINE_W-1:0] LINE_ONE   = LINE_W'(1);
   localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(H_PIXELS - 1);
   localparam logic [PIX_W-1:0]  PIX_ONE    = PIX_W'(1);
   localparam logic [DOT_W-1:0]  DOT_PORCH  = DOT_W'(H_OFFSET - 1);
   localparam logic [DOT_W-1:0]  DOT_PIX    = DOT_W'(PIXEL_DIV - 1);
   localparam logic [DOT_W-1:0]  DOT_ONE    = DOT_W'(1);

   logic hsyncEvt;
   logic vsyncEvt;
   logic syncRise;

   cap_state_e            state_q;
   logic [DOT_W-1:0]      dotCnt_q;
   logic [PIX_W-1:0]      pixCnt_q;
   logic [LINE_W-1:0]     lineIdx_q;
   logic [LINE_W-1:0]     lineIdx_d;
   logic [ADDR_WIDTH-1:0] lineBase_q;
   logic [ADDR_WIDTH-1:0] nextBase_q;
   logic [ADDR_WIDTH-1:0] wrAddr_q;
   logic [ADDR_WIDTH-1:0] wrAddr_d;
   logic [6:0]            shift_q;
   logic [7:0]            shift_d;
   logic [7:0]            wrData_q;
   logic [7:0]            frameCount_q;
   logic                  lastRow_q;
   logic                  donePend_q;
   logic                  wrEn_q;
   logic                  frameDone_q;
   logic                  syncError_q;
   logic                  inWindow;
   logic                  sample;

   video_capture_sync_detect #(
      .VSYNC_MIN (VSYNC_MIN)
   ) u_sync (
      .clk_i      (clk),
      .rst_i      (reset),
      .sync_i     (videoSync),
      .hsyncEvt_o (hsyncEvt),
      .vsyncEvt_o (vsyncEvt),
      .syncRise_o (syncRise)
   );

   always_comb begin
      shift_d   = {shift_q, videoPixel};
      wrAddr_d  = lineBase_q + ADDR_WIDTH'(pixCnt_q[PIX_W-1:3]);
      lineIdx_d = (lineIdx_q == LINE_SAT) ? lineIdx_q
                                          : lineIdx_q + LINE_ONE;
      inWindow  = (lineIdx_q >= LINE_FIRST) && (lineIdx_q < LINE_SAT);
      sample    = 1'b0;
      if (!syncRise) begin
         sample = ((state_q == CAP_H_PORCH) && (dotCnt_q == DOT_PORCH))
               || ((state_q == CAP_ACTIVE) && (dotCnt_q == DOT_PIX));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= CAP_WAIT_VSYNC;
         dotCnt_q     <= '0;
         pixCnt_q     <= '0;
         lineIdx_q    <= '0;
         lineBase_q   <= '0;
         nextBase_q   <= '0;
         wrAddr_q     <= '0;
         shift_q      <= '0;
         wrData_q     <= '0;
         frameCount_q <= '0;
         lastRow_q    <= 1'b0;
         donePend_q   <= 1'b0;
         wrEn_q       <= 1'b0;
         frameDone_q  <= 1'b0;
         syncError_q  <= 1'b0;
      end else begin
         wrEn_q      <= 1'b0;
         frameDone_q <= 1'b0;
         syncError_q <= 1'b0;

         // frameDone trails the final byte's wrEn by one cycle
         if (donePend_q) begin
            donePend_q   <= 1'b0;
            frameDone_q  <= 1'b1;
            frameCount_q <= frameCount_q + 8'd1;
         end

         if (sample) begin
            shift_q  <= shift_d[6:0];
            dotCnt_q <= '0;
            pixCnt_q <= pixCnt_q + PIX_ONE;
            if (pixCnt_q[2:0] == 3'd7) begin
               wrEn_q   <= 1'b1;
               wrData_q <= shift_d;
               wrAddr_q <= wrAddr_d;
            end
         end

         unique case (state_q)
            CAP_WAIT_VSYNC: begin
               if (vsyncEvt) begin
                  lineIdx_q  <= '0;
                  nextBase_q <= '0;
                  state_q    <= CAP_WAIT_LINE;
               end
            end
            CAP_WAIT_LINE: begin
               if (vsyncEvt) begin
                  syncError_q <= 1'b1;
                  lineIdx_q   <= '0;
                  nextBase_q  <= '0;
               end else if (hsyncEvt) begin
                  lineIdx_q <= lineIdx_d;
                  if (inWindow) begin
                     lineBase_q <= nextBase_q;
                     nextBase_q <= nextBase_q + BPR_A;
                     lastRow_q  <= (lineIdx_q == LINE_LAST);
                     dotCnt_q   <= DOT_ONE;
                     pixCnt_q   <= '0;
                     state_q    <= CAP_H_PORCH;
                  end
               end
            end
            CAP_H_PORCH: begin
               if (syncRise) begin
                  syncError_q <= 1'b1;
                  state_q     <= CAP_WAIT_LINE;
               end else if (sample) begin
                  state_q <= CAP_ACTIVE;
               end else begin
                  dotCnt_q <= dotCnt_q + DOT_ONE;
               end
            end
            CAP_ACTIVE: begin
               if (syncRise) begin
                  syncError_q <= 1'b1;
                  state_q     <= CAP_WAIT_LINE;
               end else if (sample) begin
                  if (pixCnt_q == PIX_LAST) begin
                     donePend_q <= lastRow_q;
                     state_q    <= lastRow_q ? CAP_WAIT_VSYNC
                                             : CAP_WAIT_LINE;
                  end
               end else begin
                  dotCnt_q <= dotCnt_q + DOT_ONE;
               end
            end
            default: state_q <= CAP_WAIT_VSYNC;
         endcase
      end
   end

   assign wrEn       = wrEn_q;
   assign wrAddr     = wrAddr_q;
   assign wrData     = wrData_q;
   assign frameDone  = frameDone_q;
   assign frameCount = frameCount_q;
   assign syncError  = syncError_q;

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: scoreboard bench driving sync/pixel rasters into
// video_capture and checking every byte write against expected data.
module tb_video_capture;

   localparam int PD   = 2;
   localparam int HP   = 64;
   localparam int VL   = 192;
   localparam int BPR  = HP / 8;
   localparam int TCAP = 31 + PD * HP + 6;

   typedef struct {
      logic [12:0] addr;
      logic [7:0]  data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        videoSync;
   logic        videoPixel;
   logic        wrEn;
   logic [12:0] wrAddr;
   logic [7:0]  wrData;
   logic        frameDone;
   logic [7:0]  frameCount;
   logic        syncError;

   exp_t sb[$];
   int   total;
   int   bad;
   int   cyc;
   int   lastWr;
   int   nDone;
   int   nErr;

   video_capture #(
      .PIXEL_DIV  (PD),
      .H_OFFSET   (32),
      .H_PIXELS   (HP),
      .V_OFFSET   (16),
      .V_LINES    (VL),
      .VSYNC_MIN  (64),
      .ADDR_WIDTH (13)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .videoSync  (videoSync),
      .videoPixel (videoPixel),
      .wrEn       (wrEn),
      .wrAddr     (wrAddr),
      .wrData     (wrData),
      .frameDone  (frameDone),
      .frameCount (frameCount),
      .syncError  (syncError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pbyte(input int mode, input int row,
                                        input int b);
      case (mode)
         1:       return (b == 0) ? 8'hFF : 8'h00;
         2:       return 8'hAA;
         3:       return 8'hFF;
         default: return 8'(row * 7 + b * 37 + 3);
      endcase
   endfunction

   task automatic drive_line(input int slen, input int tlen,
                             input int mode, input int row,
                             input bit push);
      exp_t       e;
      logic [7:0] by;
      int         k;
      if (push) begin
         for (int b = 0; b < BPR; b++) begin
            e.addr = 13'(row * BPR + b);
            e.data = pbyte(mode, row, b);
            sb.push_back(e);
         end
      end
      videoSync  = 1'b1;
      videoPixel = 1'b0;
      repeat (slen) tick();
      videoSync = 1'b0;
      for (int t = 0; t < tlen; t++) begin
         videoPixel = 1'b0;
         if (t >= 31) begin
            k = (t - 31) / PD;
            if (k < HP) begin
               by         = pbyte(mode, row, k / 8);
               videoPixel = by[7 - (k % 8)];
            end
         end
         tick();
      end
   endtask

   task automatic blanks(input int n);
      for (int i = 0; i < n; i++) drive_line(8, 8, 0, 0, 1'b0);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (wrEn) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL wr_extra got addr=%0d data=%02h want none",
                        wrAddr, wrData);
            end else begin
               e = sb.pop_front();
               if (wrAddr !== e.addr || wrData !== e.data) begin
                  bad++;
                  $display("FAIL wr got addr=%0d data=%02h want addr=%0d data=%02h",
                           wrAddr, wrData, e.addr, e.data);
               end
            end
            lastWr = cyc;
         end
         if (frameDone) begin
            nDone++;
            total++;
            if (cyc != lastWr + 1) begin
               bad++;
               $display("FAIL done_lag got=%0d want=%0d", cyc, lastWr + 1);
            end
         end
         if (syncError) nErr++;
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      cyc        = 0;
      lastWr     = -10;
      nDone      = 0;
      nErr       = 0;
      reset      = 1'b1;
      videoSync  = 1'b0;
      videoPixel = 1'b0;
      fork
         monitor();
      join_none
      repeat (3) tick();
      chk("rst_wrEn", 32'(wrEn), 0);
      chk("rst_wrAddr", 32'(wrAddr), 0);
      chk("rst_wrData", 32'(wrData), 0);
      chk("rst_frameDone", 32'(frameDone), 0);
      chk("rst_frameCount", 32'(frameCount), 0);
      chk("rst_syncError", 32'(syncError), 0);
      reset = 1'b0;
      repeat (4) tick();

      // hsyncs before vsync and a 63-clock pulse must not start capture
      blanks(3);
      drive_line(63, 8, 0, 0, 1'b0);
      blanks(16);
      drive_line(8, TCAP, 3, 0, 1'b0);
      chk("no_start_done", 32'(nDone), 0);

      // frame aborted by vsync after row 100
      drive_line(64, 8, 0, 0, 1'b0);
      blanks(16);
      drive_line(8, TCAP, 1, 0, 1'b1);
      for (int r = 1; r < 4; r++) drive_line(8, TCAP, 0, r, 1'b1);
      drive_line(8, TCAP, 2, 4, 1'b1);
      drive_line(8, 37, 3, 5, 1'b0);
      drive_line(8, TCAP, 0, 6, 1'b1);
      chk("abort_err", 32'(nErr), 1);
      for (int r = 7; r <= 100; r++) drive_line(8, TCAP, 0, r, 1'b1);
      drive_line(64, 8, 0, 0, 1'b0);
      chk("vsync_err", 32'(nErr), 2);
      chk("abort_count", 32'(frameCount), 0);
      chk("abort_done", 32'(nDone), 0);

      // complete frame, then a line past the window is ignored
      blanks(16);
      for (int r = 0; r < VL; r++) drive_line(8, TCAP, 0, r, 1'b1);
      chk("frame_done", 32'(nDone), 1);
      chk("frame_count", 32'(frameCount), 1);
      drive_line(8, TCAP, 3, 0, 1'b0);
      drive_line(64, 8, 0, 0, 1'b0);
      chk("frame_err", 32'(nErr), 2);
      chk("frame_sb", 32'(sb.size()), 0);

      // async reset while a write strobe is high
      blanks(16);
      videoSync = 1'b1;
      repeat (8) tick();
      videoSync  = 1'b0;
      videoPixel = 1'b1;
      repeat (46) tick();
      chk("pre_rst_wrEn", 32'(wrEn), 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_wrEn", 32'(wrEn), 0);
      chk("arst_frameDone", 32'(frameDone), 0);
      chk("arst_syncError", 32'(syncError), 0);
      chk("arst_frameCount", 32'(frameCount), 0);
      repeat (3) tick();
      reset      = 1'b0;
      videoPixel = 1'b0;
      repeat (4) tick();
      blanks(16);
      drive_line(8, TCAP, 3, 0, 1'b0);
      drive_line(64, 8, 0, 0, 1'b0);
      blanks(16);
      drive_line(8, TCAP, 1, 0, 1'b1);
      repeat (4) tick();
      chk("end_sb", 32'(sb.size()), 0);
      chk("end_err", 32'(nErr), 2);
      chk("end_done", 32'(nDone), 1);
      chk("end_count", 32'(frameCount), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_capture.md
Name: video_capture

Overview:
- Receiver end of the SoC video output: samples the videoSync/videoPixel stream and rebuilds the displayed frame as packed bytes on a frame-buffer write port.
- Sits beside SoC_tiny in the top-level wrapper and testbenches. Lets benches compare rendered screens against golden images, and lets hardware mirror the display into RAM.
- Same clock as the SoC; no clock-domain crossing.

Parameters:
- PIXEL_DIV, 4: clocks per pixel.
- H_OFFSET, 32: clocks from hsync falling edge to first pixel sample.
- H_PIXELS, 256: captured pixels per line; must be a multiple of 8.
- V_OFFSET, 16: hsync lines after vsync that are skipped.
- V_LINES, 192: captured lines per frame.
- VSYNC_MIN, 64: sync high length in clocks at or above which a pulse is a vsync.
- ADDR_WIDTH, 13: width of wrAddr; must hold H_PIXELS/8*V_LINES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- videoSync  in  1  sync, high during sync pulse.
- videoPixel  in  1  pixel data, 1 = lit.
- wrEn  out  1  one-cycle byte write strobe.
- wrAddr  out  ADDR_WIDTH  byte address = row*(H_PIXELS/8) + column byte.
- wrData  out  8  packed pixels, first sampled pixel in bit 7.
- frameDone  out  1  one-cycle pulse when a complete frame is captured.
- frameCount  out  8  completed frames, wraps 255->0.
- syncError  out  1  one-cycle pulse on a truncated line or frame.

Behaviour:
- Reset: async, active-high. All outputs 0; state WAIT_VSYNC; internal counters 0. Reset mid-line discards the partial byte and line.
- Sync measurement:
  - syncLen counts clocks while videoSync=1, saturating at VSYNC_MIN; cleared while videoSync=0.
  - An event is evaluated on the first cycle videoSync=0 after a 1 (the falling edge).
  - syncLen >= VSYNC_MIN is a vsync event; otherwise it is an hsync event.
- States:
  - WAIT_VSYNC: ignore hsyncs; on vsync, lineIdx=0 and go to WAIT_LINE.
  - WAIT_LINE: on hsync, if V_OFFSET <= lineIdx < V_OFFSET+V_LINES, set row = lineIdx-V_OFFSET and go to H_PORCH; always increment lineIdx, saturating. On vsync, restart the frame (see errors).
  - H_PORCH: dotCnt counts from 0 on the falling-edge cycle. When dotCnt = H_OFFSET-1, take the first sample that cycle and enter ACTIVE.
  - ACTIVE: sample videoPixel every PIXEL_DIV clocks. Shift MSB-first; each 8th sample registers wrData/wrAddr with wrEn=1 on the next cycle. After H_PIXELS samples, return to WAIT_LINE.
- Completion: the cycle after the final byte of row V_LINES-1 is written, frameDone pulses and frameCount increments; state becomes WAIT_VSYNC.
- Errors:
  - videoSync rising while in H_PORCH or ACTIVE: drop the partial byte, pulse syncError, return to WAIT_LINE. The sync is still measured normally. Bytes of that row already written stay; the next row starts at its own base address.
  - vsync in WAIT_LINE before the frame completes: pulse syncError, no frameDone, lineIdx=0.
  - Lines beyond the captured window are ignored until the next vsync.
- Latency: wrEn rises 1 clock after the 8th sample of a byte. At most one write per 8*PIXEL_DIV clocks.
- Address: wrAddr = row*(H_PIXELS/8) + byteIdx, computed from a registered lineBase plus byteIdx with no multiplier. Never exceeds H_PIXELS/8*V_LINES-1.

Decomposition:
- Shared include video.vh (alongside states.vh/sfr.vh): capture state encodings, default timing constants.
- One natural sub-module, video_sync_detect: syncLen counter and classifier, outputs hsyncEvt/vsyncEvt/syncRise pulses.
- Pixel shifter, address generator and FSM stay in video_capture.

Test Plan:
- Vsync of 64 clocks, 16 blank hsyncs, then hsync (8 clocks) with pixel=1 for clocks 32..63 after the fall -> wrEn with wrAddr=0 and wrData=8'hFF; next byte at wrAddr=1 has wrData=8'h00.
- Alternating pixel pattern 1,0 per pixel on a captured line 20 (row 4) -> all 32 writes carry 8'hAA at addresses 128..159.
- Full frame of 192 captured lines -> 6144 writes, addresses 0..6143 in order; frameDone once, 1 clock after the last wrEn; frameCount 0->1.
- Hsync pulses before any vsync, and a 63-clock sync -> no writes, no frameDone; a 64-clock sync then starts the capture.
- Sync rising after 3 pixels of a captured line -> syncError pulse, no wrEn for the partial byte; the next line writes at the next row base. Vsync after row 100 -> syncError, frameCount unchanged.
- Reset asserted mid-ACTIVE -> wrEn, frameDone and syncError go 0 immediately (async); frameCount=0; hsyncs ignored until a new vsync.
